// File: rtl/smvm_pkg.sv
// Shared types and constants for the sparse matrix-vector multiply front-end.
package smvm_pkg;

  localparam int DATA_W    = 8;
  localparam int CNT_W     = 8;
  localparam int K         = 4;
  localparam int VEC_DEPTH = 128;
  localparam int AW        = 7;
  localparam int LANE_W    = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VEC_IN = 3'd1,
    MAT_IN = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Occupancy mask with the lowest n lanes set.
  function automatic logic [K-1:0] lane_mask(input logic [LANE_W:0] n);
    logic [K-1:0] m;
    m = '0;
    for (int i = 0; i < K; i++) begin
      m[i] = (i < int'(n));
    end
    return m;
  endfunction

endpackage

// File: rtl/smvm_lane_packer.sv
// Packs accepted matrix beats into K-lane issue groups; a group issues when
// lane K-1 fills or the last nonzero arrives, whichever comes first.
module smvm_lane_packer
  import smvm_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     last,
  input  logic signed [DATA_W-1:0] val,
  input  logic [DATA_W-1:0]        col,
  input  logic                     ipv,
  output logic                     grp_valid,
  output logic [DATA_W*K-1:0]      grp_val,
  output logic [DATA_W*K-1:0]      grp_col,
  output logic [K-1:0]             grp_ipv,
  output logic [K-1:0]             grp_mask
);

  logic [LANE_W-1:0]        lane_cnt;
  logic signed [DATA_W-1:0] pack_val_p0 [K];
  logic [DATA_W-1:0]        pack_col_p0 [K];
  logic [K-1:0]             pack_ipv_p0;

  logic                     issue;
  logic [LANE_W:0]          fill;
  logic [DATA_W*K-1:0]      nxt_val;
  logic [DATA_W*K-1:0]      nxt_col;
  logic [K-1:0]             nxt_ipv;

  assign issue = push && ((lane_cnt == LANE_W'(K - 1)) || last);
  assign fill  = {1'b0, lane_cnt} + {{LANE_W{1'b0}}, 1'b1};

  // Stage p0 -> group: merge held lanes with the current beat, zero the rest.
  always_comb begin
    nxt_val = '0;
    nxt_col = '0;
    nxt_ipv = '0;
    for (int i = 0; i < K; i++) begin
      if (i < int'(lane_cnt)) begin
        nxt_val[i*DATA_W +: DATA_W] = pack_val_p0[i];
        nxt_col[i*DATA_W +: DATA_W] = pack_col_p0[i];
        nxt_ipv[i]                  = pack_ipv_p0[i];
      end else if (i == int'(lane_cnt)) begin
        nxt_val[i*DATA_W +: DATA_W] = val;
        nxt_col[i*DATA_W +: DATA_W] = col;
        nxt_ipv[i]                  = ipv;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push && !issue) begin
      pack_val_p0[lane_cnt] <= val;
      pack_col_p0[lane_cnt] <= col;
      pack_ipv_p0[lane_cnt] <= ipv;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt  <= '0;
      grp_valid <= 1'b0;
      grp_val   <= '0;
      grp_col   <= '0;
      grp_ipv   <= '0;
      grp_mask  <= '0;
    end else begin
      grp_valid <= issue;
      if (push) begin
        lane_cnt <= issue ? '0 : lane_cnt + 1'b1;
      end
      if (issue) begin
        grp_val  <= nxt_val;
        grp_col  <= nxt_col;
        grp_ipv  <= nxt_ipv;
        grp_mask <= lane_mask(fill);
      end
    end
  end

endmodule

// File: rtl/smvm_ctrl.sv
// Input sequencer for the SpMV datapath: header, dense vector load, matrix
// beat packing into K-lane groups, pipeline drain and completion pulse.
module smvm_ctrl
  import smvm_pkg::*;
#(
  parameter int PIPE_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     val_in,
  input  logic [DATA_W-1:0]     col_in,
  input  logic                  ipv_in,
  input  logic                  mat_last,
  output logic                  vec_we,
  output logic [AW-1:0]         vec_waddr,
  output logic [DATA_W-1:0]     vec_wdata,
  output logic                  grp_valid,
  output logic [DATA_W*K-1:0]   grp_val,
  output logic [DATA_W*K-1:0]   grp_col,
  output logic [K-1:0]          grp_ipv,
  output logic [K-1:0]          grp_mask,
  output logic [DATA_W-1:0]     rows_cfg,
  output logic [DATA_W-1:0]     cols_cfg,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   vec_count;
  logic [CNT_W-1:0]   row_cnt;
  logic [CNT_W-1:0]   drain_cnt;
  logic [CNT_W-1:0]   row_total;
  logic               accept;
  logic               hdr_ok;
  logic               vec_last;
  logic               push;

  assign in_ready  = (state == IDLE) || (state == VEC_IN) || (state == MAT_IN);
  assign accept    = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign hdr_ok    = (col_in != '0) && (col_in <= CNT_W'(VEC_DEPTH));
  assign vec_last  = (vec_count == cols_cfg - 1'b1);
  assign row_total = row_cnt + {{(CNT_W-1){1'b0}}, ipv_in};
  assign vec_waddr = vec_count[AW-1:0];
  assign vec_wdata = vec_we ? val_in : '0;

  always_comb begin
    state_nxt = state;
    vec_we    = 1'b0;
    push      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept && hdr_ok) state_nxt = VEC_IN;
      end
      VEC_IN: begin
        vec_we = accept;
        if (accept && vec_last) state_nxt = MAT_IN;
      end
      MAT_IN: begin
        push = accept;
        if (accept && mat_last) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == CNT_W'(PIPE_LAT - 1)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      vec_count <= '0;
      row_cnt   <= '0;
      drain_cnt <= '0;
      rows_cfg  <= '0;
      cols_cfg  <= '0;
      err       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            if (hdr_ok) begin
              rows_cfg  <= val_in;
              cols_cfg  <= col_in;
              err       <= 1'b0;
              vec_count <= '0;
              row_cnt   <= '0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        VEC_IN: begin
          if (accept) vec_count <= vec_last ? '0 : vec_count + 1'b1;
        end
        MAT_IN: begin
          if (accept) begin
            // Out-of-range columns are flagged but still packed downstream.
            if (col_in >= cols_cfg) err <= 1'b1;
            row_cnt <= row_total;
            if (mat_last) begin
              drain_cnt <= '0;
              if (row_total != rows_cfg) err <= 1'b1;
            end
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  smvm_lane_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .last      (mat_last),
    .val       (val_in),
    .col       (col_in),
    .ipv       (ipv_in),
    .grp_valid (grp_valid),
    .grp_val   (grp_val),
    .grp_col   (grp_col),
    .grp_ipv   (grp_ipv),
    .grp_mask  (grp_mask)
  );

endmodule
